// File: rtl/kw11l_clock.sv
// KW11-L style line clock: programmable tick divider, CSR on a Wishbone slave port,
// vectored interrupt handshake and a debounced front-panel enable button.
module kw11l_clock #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 50,
  parameter int unsigned DEB_LEN = 2,
  parameter bit          INIT_EN = 1'b1,
  parameter logic [15:0] VECTOR  = 16'o000100,
  parameter bit          LEGACY  = 1'b0
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq_o,
  input  logic        istb_i,
  output logic        iack_o,
  output logic [15:0] ivec_o,
  input  logic        timer_button,
  output logic        timer_status,
  output logic        tick_o
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         sync_q, sync_d;
  logic [DEB_LEN-1:0] deb_q, deb_d;
  logic               armed_q, armed_d;
  logic               status_q, status_d;
  logic               done_q, done_d;
  logic               ie_q, ie_d;
  logic               irq_q, irq_d;
  logic               ack_q, ack_d;
  logic [15:0]        dat_q, dat_d;
  logic               iack_q, iack_d;
  logic [15:0]        ivec_q, ivec_d;

  logic tick;
  logic req;
  logic wr_en;
  logic unused_ok;

  assign tick  = (cnt_q == CntMax);
  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  // Writes commit at the end of the ack cycle, so a reset during ack drops them.
  assign wr_en = ack_q & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[0];

  assign unused_ok = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_comb begin
    sync_d   = {sync_q[0], timer_button};
    deb_d    = deb_q;
    armed_d  = armed_q;
    status_d = status_q;
    if (tick) begin
      deb_d = DEB_LEN'({deb_q, sync_q[1]});
      if ((&deb_d) && armed_q) begin
        status_d = ~status_q;
        armed_d  = 1'b0;
      end else if (~|deb_d) begin
        armed_d = 1'b1;
      end
    end
  end

  always_comb begin
    ack_d  = req;
    dat_d  = req ? {8'b0, done_q, ie_q, 6'b0} : '0;
    done_d = done_q;
    ie_d   = ie_q;
    if (wr_en) begin
      ie_d = wb_dat_i[6];
      if (!wb_dat_i[7]) done_d = 1'b0;
    end
    if (tick && status_q) done_d = 1'b1;

    iack_d = ~LEGACY & istb_i & irq_q & ~iack_q;
    ivec_d = iack_d ? VECTOR : '0;

    // Priority: ack clear < tick/IE-enable set < explicit IE=0 write.
    irq_d = irq_q;
    if (iack_d) irq_d = 1'b0;
    if (tick && status_q && ie_q) irq_d = 1'b1;
    if (wr_en && !ie_q && wb_dat_i[6] && done_d) irq_d = 1'b1;
    if (wr_en && !wb_dat_i[6]) irq_d = 1'b0;
    if (LEGACY) irq_d = 1'b0;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sync_q   <= '0;
      deb_q    <= '0;
      armed_q  <= 1'b1;
      status_q <= INIT_EN;
      done_q   <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      iack_q   <= 1'b0;
      ivec_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      deb_q    <= deb_d;
      armed_q  <= armed_d;
      status_q <= status_d;
      done_q   <= done_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      iack_q   <= iack_d;
      ivec_q   <= ivec_d;
    end
  end

  assign tick_o       = tick;
  assign timer_status = status_q;
  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign iack_o       = iack_q;
  assign ivec_o       = ivec_q;
  assign irq_o        = LEGACY ? (tick & status_q) : irq_q;

endmodule

// File: tb/tb_kw11l_clock.sv
// Directed bench for kw11l_clock: DIV=10 vectored instance plus a LEGACY instance
// sharing the same stimulus.
module tb_kw11l_clock;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        istb_i;
  logic        timer_button;

  logic [15:0] wb_dat_o, ivec_o;
  logic        wb_ack_o, irq_o, iack_o, timer_status, tick_o;
  logic [15:0] leg_dat, leg_ivec;
  logic        leg_ack, leg_irq, leg_iack, leg_status, leg_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk_p = ~clk_p;

  kw11l_clock #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEB_LEN(2), .INIT_EN(1'b1),
    .VECTOR(16'o000100), .LEGACY(1'b0)
  ) u_dut (
    .clk_p(clk_p), .rst_n(rst_n), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .irq_o(irq_o), .istb_i(istb_i), .iack_o(iack_o),
    .ivec_o(ivec_o), .timer_button(timer_button), .timer_status(timer_status),
    .tick_o(tick_o)
  );

  kw11l_clock #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEB_LEN(2), .INIT_EN(1'b1),
    .VECTOR(16'o000100), .LEGACY(1'b1)
  ) u_leg (
    .clk_p(clk_p), .rst_n(rst_n), .wb_dat_i(wb_dat_i), .wb_dat_o(leg_dat),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(leg_ack), .irq_o(leg_irq), .istb_i(istb_i), .iack_o(leg_iack),
    .ivec_o(leg_ivec), .timer_button(timer_button), .timer_status(leg_status),
    .tick_o(leg_tick)
  );

  typedef enum int {OpRd, OpWr, OpIstb} op_e;
  typedef struct {
    int          idle;
    op_e         op;
    logic [1:0]  sel;
    logic [15:0] wdat;
    logic [15:0] exp_rd;
    logic        exp_iack;
    logic [15:0] exp_vec;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic wb_op(input bit we, input logic [1:0] sel, input logic [15:0] wdat,
                       output logic [15:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_sel_i = sel; wb_dat_i = wdat;
    step();
    check("ack_rise", 16'(wb_ack_o), 16'd1);
    rd = wb_dat_o;
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 2'b00; wb_dat_i = '0;
    check("ack_drop", 16'(wb_ack_o), 16'd0);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      if (tick_o) seen = 1'b1;
      else step();
    end
    check("tick_timeout", 16'(seen), 16'd1);
  endtask

  task automatic run_button(input int cycles, output int toggles, output int ticks_at);
    logic prev;
    int   nt;
    toggles = 0; nt = 0; ticks_at = -1; prev = timer_status;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (timer_status !== prev) begin
        toggles++;
        if (ticks_at < 0) ticks_at = nt;
        prev = timer_status;
      end
      if (tick_o) nt++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int tg, ta, tg2, ta2;

    // Positions are cycles after a tick cycle (tick cycles at 0, 10, 20, ...).
    tbl[0]  = '{0, OpRd,   2'b01, 16'o000000, 16'o000200, 1'b0, 16'o000000, 1'b0};
    tbl[1]  = '{0, OpWr,   2'b01, 16'o000100, 16'o000000, 1'b0, 16'o000000, 1'b0};
    tbl[2]  = '{0, OpRd,   2'b01, 16'o000000, 16'o000100, 1'b0, 16'o000000, 1'b0};
    tbl[3]  = '{5, OpRd,   2'b01, 16'o000000, 16'o000300, 1'b0, 16'o000000, 1'b1};
    tbl[4]  = '{0, OpIstb, 2'b00, 16'o000000, 16'o000000, 1'b1, 16'o000100, 1'b0};
    tbl[5]  = '{0, OpIstb, 2'b00, 16'o000000, 16'o000000, 1'b0, 16'o000000, 1'b0};
    tbl[6]  = '{0, OpWr,   2'b01, 16'o000200, 16'o000000, 1'b0, 16'o000000, 1'b0};
    tbl[7]  = '{0, OpWr,   2'b01, 16'o000300, 16'o000000, 1'b0, 16'o000000, 1'b1};
    tbl[8]  = '{8, OpWr,   2'b01, 16'o000000, 16'o000000, 1'b0, 16'o000000, 1'b0};
    tbl[9]  = '{0, OpRd,   2'b01, 16'o000000, 16'o000200, 1'b0, 16'o000000, 1'b0};
    tbl[10] = '{0, OpWr,   2'b10, 16'o000100, 16'o000000, 1'b0, 16'o000000, 1'b0};
    tbl[11] = '{0, OpRd,   2'b01, 16'o000000, 16'o000200, 1'b0, 16'o000000, 1'b0};

    rst_n = 1'b0; wb_dat_i = '0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 2'b00; istb_i = 1'b0; timer_button = 1'b0;
    repeat (3) step();

    check("rst_ack", 16'(wb_ack_o), 16'd0);
    check("rst_dat", wb_dat_o, 16'd0);
    check("rst_irq", 16'(irq_o), 16'd0);
    check("rst_iack", 16'(iack_o), 16'd0);
    check("rst_ivec", ivec_o, 16'd0);
    check("rst_tick", 16'(tick_o), 16'd0);
    check("rst_status", 16'(timer_status), 16'd1);
    check("rst_leg_dat", leg_dat, 16'd0);
    check("rst_leg_status", 16'(leg_status), 16'd1);

    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) step();
      check($sformatf("tick_n%0d", n), 16'(tick_o), 16'((n % 10) == 9));
      check($sformatf("leg_tick_n%0d", n), 16'(leg_tick), 16'((n % 10) == 9));
      check($sformatf("leg_irq_n%0d", n), 16'(leg_irq), 16'((n % 10) == 9));
    end

    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].idle) step();
      if (tbl[i].op == OpIstb) begin
        istb_i = 1'b1;
        step();
        istb_i = 1'b0;
        check($sformatf("iack_v%0d", i), 16'(iack_o), 16'(tbl[i].exp_iack));
        check($sformatf("ivec_v%0d", i), ivec_o, tbl[i].exp_vec);
        check($sformatf("leg_iack_v%0d", i), 16'(leg_iack), 16'd0);
        check($sformatf("leg_ivec_v%0d", i), leg_ivec, 16'd0);
        step();
        check($sformatf("iack_drop_v%0d", i), 16'(iack_o), 16'd0);
        check($sformatf("ivec_drop_v%0d", i), ivec_o, 16'd0);
      end else begin
        wb_op(tbl[i].op == OpWr, tbl[i].sel, tbl[i].wdat, rd);
        if (tbl[i].op == OpRd) check($sformatf("rdat_v%0d", i), rd, tbl[i].exp_rd);
      end
      check($sformatf("irq_v%0d", i), 16'(irq_o), 16'(tbl[i].exp_irq));
    end

    // Held strobe: ack on cycles 1 and 3 only.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_sel_i = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("held_ack_c%0d", c), 16'(wb_ack_o), 16'(c % 2));
      check($sformatf("held_leg_ack_c%0d", c), 16'(leg_ack), 16'(c % 2));
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = 2'b00;

    // Button held five ticks: one toggle, on the second tick after sync.
    timer_button = 1'b1;
    run_button(50, tg, ta);
    check("press1_toggles", 16'(tg), 16'd1);
    check("press1_tick", 16'(ta), 16'd2);
    check("press1_status", 16'(timer_status), 16'd0);
    check("press1_leg_status", 16'(leg_status), 16'd0);
    timer_button = 1'b0;

    // Disabled: ticks continue, no DONE, no legacy irq.
    wb_op(1'b1, 2'b01, 16'o000000, rd);
    for (int c = 0; c < 20; c++) begin
      step();
      if (tick_o) check("off_leg_irq", 16'(leg_irq), 16'd0);
    end
    wb_op(1'b0, 2'b01, 16'o000000, rd);
    check("off_done", rd, 16'o000000);
    check("off_irq", 16'(irq_o), 16'd0);
    repeat (10) step();

    timer_button = 1'b1;
    run_button(50, tg, ta);
    check("press2_toggles", 16'(tg), 16'd1);
    check("press2_status", 16'(timer_status), 16'd1);
    timer_button = 1'b0;
    repeat (30) step();

    // One-tick glitch: no toggle.
    timer_button = 1'b1;
    run_button(10, tg, ta);
    timer_button = 1'b0;
    run_button(40, tg2, ta2);
    check("glitch_toggles", 16'(tg + tg2), 16'd0);
    check("glitch_status", 16'(timer_status), 16'd1);

    // Pending irq and an in-flight ack are dropped by reset.
    wb_op(1'b1, 2'b01, 16'o000100, rd);
    wait_tick();
    step();
    check("pre_rst_irq", 16'(irq_o), 16'd1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_sel_i = 2'b01;
    step();
    check("pre_rst_ack", 16'(wb_ack_o), 16'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 16'(wb_ack_o), 16'd0);
    check("midrst_irq", 16'(irq_o), 16'd0);
    check("midrst_dat", wb_dat_o, 16'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
